// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state, access-size encodings and counter width for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int CNT_W = 16;

endpackage

// File: rtl/lsu_addr_check.sv
// lsu_addr_check: request legality check and natural alignment of the address (macro LSU_MISALIGN_TRAP_EN makes misalignment an error)
module lsu_addr_check
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    output logic        err,
    output logic [31:0] aligned_addr
);

    // Clear the low address bits below the access size; size 3 never reaches memory.
    always_comb begin
        aligned_addr = size == SIZE_W ? {addr[31:2], 2'b00} :
                       size == SIZE_H ? {addr[31:1], 1'b0}  : addr;
`ifdef LSU_MISALIGN_TRAP_EN
        err = size == 2'd3 || (size == SIZE_H && addr[0]) || (size == SIZE_W && addr[1:0] != 2'b00);
`else
        err = size == 2'd3;
`endif
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store front end to a data memory / MMIO responder (optional macro LSU_MISALIGN_TRAP_EN)
module load_store_unit
    import lsu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_sign,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [31:0]      mem_addr,
    output logic [1:0]       mem_length,
    output logic             mem_sign,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    lsu_state_e       state_q, state_d;
    logic             we_q, sign_q, err_q;
    logic [1:0]       size_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [CNT_W-1:0] load_cnt_q, store_cnt_q;
    logic             chk_err, accept, done;
    logic [31:0]      chk_addr;

    lsu_addr_check u_addr_check (
        .size         (req_size),
        .addr         (req_addr),
        .err          (chk_err),
        .aligned_addr (chk_addr)
    );

    assign accept = req_valid && req_ready;
    assign done   = state_q == RESP && resp_ready;

    // Next state and state-decoded handshake/strobe outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_d = chk_err ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_read  = !we_q;
                mem_write = we_q;
                state_d   = we_q ? RESP : WAIT;
            end
            WAIT: state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_length = size_q;
    assign mem_sign   = sign_q;
    assign mem_wdata  = wdata_q;
    assign load_cnt   = load_cnt_q;
    assign store_cnt  = store_cnt_q;

    // State register, request latch, read-data capture and saturating completion counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                sign_q  <= req_sign;
                err_q   <= chk_err;
                size_q  <= req_size;
                addr_q  <= chk_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if (state_q == WAIT) rdata_q <= mem_rdata;
            if (done && !err_q && !we_q && load_cnt_q != '1) load_cnt_q <= load_cnt_q + 1'b1;
            if (done && !err_q && we_q && store_cnt_q != '1) store_cnt_q <= store_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized transactions against a transaction-level reference model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_size = 2'd0, mem_length;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_sign, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [15:0] load_cnt, store_cnt;

    int          n_chk = 0, n_fail = 0;
    int          exp_ld = 0, exp_st = 0;
    logic [31:0] rd_value = '0;
    logic        rd_pend = 1'b0;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_length (mem_length),
        .mem_sign   (mem_sign),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt)
    );

    always #5 clk = ~clk;

    // Responder: read data appears on the negedge one cycle after the read strobe, junk otherwise.
    always @(negedge clk) begin
        mem_rdata = rd_pend ? rd_value : $urandom;
        rd_pend   = mem_read;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_txn(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rval, input int hold, input logic junk);
        logic        exp_err;
        logic [31:0] exp_addr, exp_rd;
        int          exp_lat, lat, n_rd, n_wr;
        exp_err = size == 2'd3;
`ifdef LSU_MISALIGN_TRAP_EN
        exp_err = exp_err || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
`endif
        exp_addr = size == 2'd2 ? addr - addr % 4 : size == 2'd1 ? addr - addr % 2 : addr;
        exp_lat  = exp_err ? 1 : we ? 2 : 3;
        exp_rd   = (exp_err || we) ? 32'd0 : rval;
        rd_value = rval;
        chk("req_ready_idle", req_ready, 1);
        req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1; resp_ready = 1'b0;
        lat = 0; n_rd = 0; n_wr = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            if (junk) begin
                req_valid = 1'b1; req_we = $urandom; req_size = $urandom;
                req_addr = $urandom; req_wdata = $urandom; req_sign = $urandom;
            end else req_valid = 1'b0;
            if (mem_read || mem_write) begin
                n_rd += int'(mem_read);
                n_wr += int'(mem_write);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_length", mem_length, size);
                chk("mem_sign", mem_sign, sign);
                if (we) chk("mem_wdata", mem_wdata, wdata);
            end
            if (resp_valid) lat = k;
        end
        chk("n_read", n_rd, (!exp_err && !we) ? 1 : 0);
        chk("n_write", n_wr, (!exp_err && we) ? 1 : 0);
        chk("latency", lat, exp_lat);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", resp_err, exp_err);
        for (int d = 0; d < hold; d++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_err", resp_err, exp_err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_no_mem", mem_read | mem_write, 0);
        end
        if (!exp_err && we && exp_st < 65535) exp_st++;
        if (!exp_err && !we && exp_ld < 65535) exp_ld++;
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_done", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        chk("load_cnt", load_cnt, exp_ld);
        chk("store_cnt", store_cnt, exp_st);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_rw", {mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_cnt", {load_cnt, store_cnt}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        run_txn(1'b1, 2'd0, 1'b0, 32'h8000_0000, 32'h0000_00A5, 32'h1234_5678, 0, 1'b0);
        run_txn(1'b0, 2'd1, 1'b1, 32'h0000_0003, 32'h0, 32'h0000_BEEF, 1, 1'b0);
        run_txn(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
        run_txn(1'b1, 2'd3, 1'b0, 32'h0000_0024, 32'h5555_AAAA, 32'h0, 0, 1'b1);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_CAFE, 5, 1'b1);
        run_txn(1'b1, 2'd2, 1'b1, 32'h0000_0106, 32'h7777_1111, 32'h0, 5, 1'b1);

        for (int i = 0; i < 40; i++)
            run_txn($urandom, ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                    $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom);

        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0300; rd_value = 32'h1357_9BDF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_read", mem_read, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_cnt", {load_cnt, store_cnt}, 0);
        exp_ld = 0; exp_st = 0;
        @(negedge clk);
        rst = 1'b1;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("postrst_no_resp", resp_valid | mem_read | mem_write, 0);
        end
        resp_ready = 1'b0;
        chk("postrst_cnt", {load_cnt, store_cnt}, 0);

        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0402, 32'hABCD_0123, 32'h0, 2, 1'b0);
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0405, 32'h0, 32'h0000_00F0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
